// File: rtl/data_mem_unit.sv
// Data memory for the MEM stage: byte-addressable word array with sized,
// sign/zero-extended loads, lane-masked stores, a sticky fault flag that
// records the first faulting address, and access counters.
module data_mem_unit #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic        mem_r,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] err_addr,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem_q [DEPTH];
  logic                  err_q, err_d;
  logic [31:0]           err_addr_q, err_addr_d;
  logic [31:0]           load_cnt_q, load_cnt_d;
  logic [31:0]           store_cnt_q, store_cnt_d;

  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           rd_word;
  logic [15:0]           rd_half;
  logic [7:0]            rd_byte;
  logic                  is_word, is_half, is_byte, is_rsvd;
  logic                  access, fault, store_ok, load_ok;
  logic [3:0]            lane_en;
  logic [31:0]           lane_data;
  logic                  unused_addr_hi;

  // Higher address bits only alias; they never select anything.
  assign unused_addr_hi = ^addr[31:DEPTH_LOG2+2];

  assign word_idx = addr[DEPTH_LOG2+1:2];
  assign rd_word  = mem_q[word_idx];
  assign rd_half  = addr[1] ? rd_word[31:16] : rd_word[15:0];

  // Select the addressed byte of the current word.
  always_comb begin
    rd_byte = rd_word[7:0];
    case (addr[1:0])
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      2'd3:    rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  assign is_word = (dm_ctrl == 3'd0);
  assign is_half = (dm_ctrl == 3'd1) || (dm_ctrl == 3'd2);
  assign is_byte = (dm_ctrl == 3'd3) || (dm_ctrl == 3'd4);
  assign is_rsvd = !(is_word || is_half || is_byte);

  // A request with no mem_w/mem_r is not an access, so it can never fault.
  assign access   = mem_w || mem_r;
  assign fault    = access && (is_rsvd
                             || (is_word && (addr[1:0] != 2'b00))
                             || (is_half && addr[0]));
  assign store_ok = mem_w && !fault;
  // A simultaneous load+store is counted as a store only.
  assign load_ok  = mem_r && !mem_w && !fault;

  // Load extraction; a faulting load returns zero.
  always_comb begin
    rdata = '0;
    case (dm_ctrl)
      3'd0:    rdata = rd_word;
      3'd1:    rdata = {{16{rd_half[15]}}, rd_half};
      3'd2:    rdata = {16'h0000, rd_half};
      3'd3:    rdata = {{24{rd_byte[7]}}, rd_byte};
      3'd4:    rdata = {24'h000000, rd_byte};
      default: rdata = '0;
    endcase
    if (mem_r && fault) rdata = '0;
  end

  // Byte-lane enables and lane-replicated store data.
  always_comb begin
    lane_en   = 4'b0000;
    lane_data = wdata;
    if (is_word) begin
      lane_en = 4'b1111;
    end else if (is_half) begin
      lane_en   = addr[1] ? 4'b1100 : 4'b0011;
      lane_data = {wdata[15:0], wdata[15:0]};
    end else if (is_byte) begin
      lane_en   = 4'b0001 << addr[1:0];
      lane_data = {4{wdata[7:0]}};
    end
  end

  // Next-state for the fault capture and the counters.
  always_comb begin
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (fault && !err_q) begin
      err_d      = 1'b1;
      err_addr_d = addr;
    end
    if (load_ok)  load_cnt_d  = load_cnt_q + 32'd1;
    if (store_ok) store_cnt_d = store_cnt_q + 32'd1;
  end

  // Array: cleared by reset, lane-masked write on an accepted store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (store_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem_q[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

  // Status and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: sized loads/stores, faults, aliasing,
// simultaneous load/store and asynchronous reset.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_w, mem_r;
  logic [31:0] addr, wdata;
  logic [2:0]  dm_ctrl;
  logic [31:0] rdata, err_addr, load_cnt, store_cnt;
  logic        err;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_lc = 0;
  logic [31:0] exp_sc = 0;

  data_mem_unit #(.DEPTH_LOG2(8)) dut (
    .clk(clk), .reset(reset), .mem_w(mem_w), .mem_r(mem_r),
    .addr(addr), .wdata(wdata), .dm_ctrl(dm_ctrl),
    .rdata(rdata), .err(err), .err_addr(err_addr),
    .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    @(negedge clk);
    mem_w = 1'b1; mem_r = 1'b0; addr = a; wdata = d; dm_ctrl = c;
    @(posedge clk); #1;
    mem_w = 1'b0;
  endtask

  task automatic start_load(input logic [31:0] a, input logic [2:0] c);
    @(negedge clk);
    mem_w = 1'b0; mem_r = 1'b1; addr = a; dm_ctrl = c;
    #1;
  endtask

  task automatic end_cycle();
    @(posedge clk); #1;
    mem_w = 1'b0; mem_r = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_w = 1'b0; mem_r = 1'b0; addr = 32'h10; wdata = '0; dm_ctrl = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (err_addr !== 32'h0) begin bad++; $display("FAIL reset_err_addr got=%h exp=0", err_addr); end
    total++; if (load_cnt !== 32'h0 || store_cnt !== 32'h0) begin bad++; $display("FAIL reset_cnts got=%h/%h exp=0/0", load_cnt, store_cnt); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_word();
    do_store(32'h10, 32'h8badf00d, 3'd0); exp_sc++;
    start_load(32'h10, 3'd0);
    total++; if (rdata !== 32'h8badf00d) begin bad++; $display("FAIL word_load got=%h exp=%h", rdata, 32'h8badf00d); end
    end_cycle(); exp_lc++;
    total++; if (store_cnt !== exp_sc || load_cnt !== exp_lc) begin bad++; $display("FAIL word_cnts got=%0d/%0d exp=%0d/%0d", store_cnt, load_cnt, exp_sc, exp_lc); end
  endtask

  task automatic test_byte_half();
    do_store(32'h13, 32'hffffff7f, 3'd3); exp_sc++;
    start_load(32'h13, 3'd3);
    total++; if (rdata !== 32'h0000007f) begin bad++; $display("FAIL lb_13 got=%h exp=%h", rdata, 32'h7f); end
    end_cycle(); exp_lc++;
    start_load(32'h10, 3'd4);
    total++; if (rdata !== 32'h0000000d) begin bad++; $display("FAIL lbu_10 got=%h exp=%h", rdata, 32'h0d); end
    end_cycle(); exp_lc++;
    start_load(32'h12, 3'd1);
    total++; if (rdata !== 32'h00007fad) begin bad++; $display("FAIL lh_12 got=%h exp=%h", rdata, 32'h7fad); end
    end_cycle(); exp_lc++;
    start_load(32'h11, 3'd3);
    total++; if (rdata !== 32'hfffffff0) begin bad++; $display("FAIL lb_11 got=%h exp=%h", rdata, 32'hfffffff0); end
    end_cycle(); exp_lc++;
    start_load(32'h10, 3'd0);
    total++; if (rdata !== 32'h7fadf00d) begin bad++; $display("FAIL lw_10_after_sb got=%h exp=%h", rdata, 32'h7fadf00d); end
    end_cycle(); exp_lc++;
  endtask

  task automatic test_half_signed();
    do_store(32'h20, 32'h12348001, 3'd1); exp_sc++;
    start_load(32'h20, 3'd1);
    total++; if (rdata !== 32'hffff8001) begin bad++; $display("FAIL lh_20 got=%h exp=%h", rdata, 32'hffff8001); end
    end_cycle(); exp_lc++;
    start_load(32'h20, 3'd2);
    total++; if (rdata !== 32'h00008001) begin bad++; $display("FAIL lhu_20 got=%h exp=%h", rdata, 32'h8001); end
    end_cycle(); exp_lc++;
    start_load(32'h20, 3'd0);
    total++; if (rdata !== 32'h00008001) begin bad++; $display("FAIL lw_20 got=%h exp=%h", rdata, 32'h8001); end
    end_cycle(); exp_lc++;
    do_store(32'h2e, 32'h0000beef, 3'd2); exp_sc++;
    start_load(32'h2c, 3'd0);
    total++; if (rdata !== 32'hbeef0000) begin bad++; $display("FAIL sh_upper got=%h exp=%h", rdata, 32'hbeef0000); end
    end_cycle(); exp_lc++;
  endtask

  task automatic test_misalign();
    do_store(32'h22, 32'hdeadbeef, 3'd0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL mis_err got=%b exp=1", err); end
    total++; if (err_addr !== 32'h22) begin bad++; $display("FAIL mis_err_addr got=%h exp=%h", err_addr, 32'h22); end
    total++; if (store_cnt !== exp_sc) begin bad++; $display("FAIL mis_store_cnt got=%0d exp=%0d", store_cnt, exp_sc); end
    start_load(32'h31, 3'd1);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL mis_load_rdata got=%h exp=0", rdata); end
    end_cycle();
    total++; if (err_addr !== 32'h22 || err !== 1'b1) begin bad++; $display("FAIL mis_sticky got=%b/%h exp=1/%h", err, err_addr, 32'h22); end
    total++; if (load_cnt !== exp_lc) begin bad++; $display("FAIL mis_load_cnt got=%0d exp=%0d", load_cnt, exp_lc); end
    start_load(32'h20, 3'd0);
    total++; if (rdata !== 32'h00008001) begin bad++; $display("FAIL mis_word_kept got=%h exp=%h", rdata, 32'h8001); end
    end_cycle(); exp_lc++;
  endtask

  task automatic test_back_to_back();
    do_store(32'h40, 32'h11111111, 3'd0); exp_sc++;
    @(negedge clk);
    mem_w = 1'b1; mem_r = 1'b1; addr = 32'h40; wdata = 32'h22222222; dm_ctrl = 3'd0;
    #1;
    total++; if (rdata !== 32'h11111111) begin bad++; $display("FAIL rw_pre got=%h exp=%h", rdata, 32'h11111111); end
    end_cycle(); exp_sc++;
    total++; if (store_cnt !== exp_sc || load_cnt !== exp_lc) begin bad++; $display("FAIL rw_cnts got=%0d/%0d exp=%0d/%0d", store_cnt, load_cnt, exp_sc, exp_lc); end
    start_load(32'h40, 3'd0);
    total++; if (rdata !== 32'h22222222) begin bad++; $display("FAIL rw_post got=%h exp=%h", rdata, 32'h22222222); end
    end_cycle(); exp_lc++;
  endtask

  task automatic test_alias();
    start_load(32'h440, 3'd0);
    total++; if (rdata !== 32'h22222222) begin bad++; $display("FAIL alias_load got=%h exp=%h", rdata, 32'h22222222); end
    end_cycle(); exp_lc++;
    do_store(32'h1041, 32'h000000a5, 3'd4); exp_sc++;
    start_load(32'h40, 3'd0);
    total++; if (rdata !== 32'h2222a522) begin bad++; $display("FAIL alias_store got=%h exp=%h", rdata, 32'h2222a522); end
    end_cycle(); exp_lc++;
  endtask

  task automatic test_reserved();
    start_load(32'h40, 3'd5);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rsvd_load got=%h exp=0", rdata); end
    end_cycle();
    do_store(32'h40, 32'hffffffff, 3'd7);
    start_load(32'h42, 3'd0);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL mis_word_load got=%h exp=0", rdata); end
    end_cycle();
    total++; if (store_cnt !== exp_sc || load_cnt !== exp_lc) begin bad++; $display("FAIL rsvd_cnts got=%0d/%0d exp=%0d/%0d", store_cnt, load_cnt, exp_sc, exp_lc); end
    total++; if (err_addr !== 32'h22) begin bad++; $display("FAIL rsvd_err_addr got=%h exp=%h", err_addr, 32'h22); end
    @(negedge clk);
    mem_w = 1'b0; mem_r = 1'b0; addr = 32'h40; dm_ctrl = 3'd0;
    #1;
    total++; if (rdata !== 32'h2222a522) begin bad++; $display("FAIL idle_read got=%h exp=%h", rdata, 32'h2222a522); end
    end_cycle();
    total++; if (store_cnt !== exp_sc || load_cnt !== exp_lc) begin bad++; $display("FAIL idle_cnts got=%0d/%0d exp=%0d/%0d", store_cnt, load_cnt, exp_sc, exp_lc); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    mem_w = 1'b0; mem_r = 1'b0; addr = 32'h40; dm_ctrl = 3'd0;
    #2 reset = 1'b0;
    #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL areset_rdata got=%h exp=0", rdata); end
    total++; if (err !== 1'b0 || err_addr !== 32'h0) begin bad++; $display("FAIL areset_err got=%b/%h exp=0/0", err, err_addr); end
    total++; if (load_cnt !== 32'h0 || store_cnt !== 32'h0) begin bad++; $display("FAIL areset_cnts got=%h/%h exp=0/0", load_cnt, store_cnt); end
    mem_w = 1'b1; addr = 32'h50; wdata = 32'hcafef00d;
    @(posedge clk); #1;
    @(negedge clk);
    mem_w = 1'b0; reset = 1'b1;
    exp_lc = 0; exp_sc = 0;
    start_load(32'h50, 3'd0);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL areset_discard got=%h exp=0", rdata); end
    end_cycle(); exp_lc++;
    do_store(32'h50, 32'hcafef00d, 3'd0); exp_sc++;
    start_load(32'h50, 3'd0);
    total++; if (rdata !== 32'hcafef00d) begin bad++; $display("FAIL post_reset_store got=%h exp=%h", rdata, 32'hcafef00d); end
    end_cycle(); exp_lc++;
    total++; if (store_cnt !== exp_sc || load_cnt !== exp_lc) begin bad++; $display("FAIL post_reset_cnts got=%0d/%0d exp=%0d/%0d", store_cnt, load_cnt, exp_sc, exp_lc); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_half_signed();
    test_misalign();
    test_back_to_back();
    test_alias();
    test_reserved();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter DEPTH_LOG2, default 8: memory holds 2^DEPTH_LOG2 32-bit words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 mem_w  input  1  store request for the current cycle.
REQ-005 mem_r  input  1  load request for the current cycle.
REQ-006 addr  input  32  byte address from the MEM-stage ALU result.
REQ-007 wdata  input  32  store data from the MEM-stage rs2 value; byte/half data taken from the low bits.
REQ-008 dm_ctrl  input  3  access size: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned, 101-111 reserved.
REQ-009 rdata  output  32  load result, extended per dm_ctrl.
REQ-010 err  output  1  sticky misalign/illegal-access flag.
REQ-011 err_addr  output  32  address of the first faulting access.
REQ-012 load_cnt  output  32  count of accepted loads.
REQ-013 store_cnt  output  32  count of accepted stores.

Function
REQ-014 Word index is addr[DEPTH_LOG2+1:2]; higher address bits are ignored, so addresses alias modulo 4*2^DEPTH_LOG2.
REQ-015 Read is combinational, with zero-cycle latency: rdata reflects the array contents and the current addr/dm_ctrl in the same cycle.
REQ-016 Write is synchronous: an accepted store updates only the selected byte lanes at the rising edge.
REQ-017 Byte-lane selection:
- word writes lanes 3:0
- half writes lanes {addr[1]*2+1, addr[1]*2}
- byte writes lane addr[1:0]
REQ-018 Load extraction:
- byte selected by addr[1:0]
- half selected by addr[1]
- signed variants sign-extend bit 7 or bit 15; unsigned variants zero-extend
REQ-019 An access is faulting when any of the following holds:
- word access with addr[1:0]!=0
- half access with addr[0]!=0
- dm_ctrl is reserved and mem_w or mem_r is 1
REQ-020 A faulting store leaves the array unchanged and does not increment store_cnt.
REQ-021 A faulting load drives rdata=0 and does not increment load_cnt.
REQ-022 err handling on a faulting access:
- err sets at the next rising edge
- err_addr captures addr only if err was 0 before that edge
- both hold until reset
REQ-023 When mem_w=mem_r=1 in one cycle, the store is performed and counted as a store only. rdata shows the pre-write word.
REQ-024 When mem_w=mem_r=0, rdata still shows the combinational read of addr, and no state changes.
REQ-025 load_cnt and store_cnt are 32-bit and wrap from 0xFFFFFFFF to 0 without affecting err.
REQ-026 A load from a word written in the previous cycle returns the new data; no bypass is needed because the write completes at the edge.

Reset
REQ-027 While reset=0, all of the following are forced asynchronously and held: all array words 0, err=0, err_addr=0, load_cnt=0, store_cnt=0.
REQ-028 A store coinciding with the rising edge while reset=0 is discarded.
REQ-029 After reset deasserts, the first rising edge with a valid store is accepted normally.
REQ-030 During reset rdata=0, since the array is cleared.

Verification
REQ-031 Store word 0x8badf00d at addr 0x10, then load word at 0x10 -> rdata=0x8badf00d, store_cnt=1, load_cnt=1.
REQ-032 After REQ-031, the following must hold:
- store byte 0x7f to 0x13
- load byte signed at 0x13 -> rdata=0x0000007f
- load byte unsigned at 0x10 -> rdata=0x0000000d
- load half signed at 0x12 -> rdata=0x00007fad
REQ-033 Store half 0x8001 to 0x20, then load half signed at 0x20 -> rdata=0xFFFF8001; load half unsigned -> 0x00008001.
REQ-034 Misalign sequence -> err=1, err_addr=0x22, word at 0x20 unchanged, store_cnt not incremented:
- word store at 0x22
- then half load at 0x31
REQ-035 Simultaneous mem_w=mem_r=1 word at 0x40 with prior content 0x11111111, wdata 0x22222222 -> rdata=0x11111111 that cycle; next cycle read returns 0x22222222; only store_cnt increments.
REQ-036 Assert reset=0 mid-sequence between clock edges -> all outputs and the array clear immediately. A store presented during reset is not written; a read of its address after release returns 0.
